// File: rtl/matrix_location_broadcaster_if.sv
// rtl/matrix_location_broadcaster_if.sv - upstream location handshake plus per-channel broadcast handshakes
interface matrix_location_broadcaster_if #(
  parameter int layer_index_size = 32,
  parameter int row_index_size   = 32,
  parameter int channel_count    = 2,
  parameter int count_size       = 16
);
  logic                                       in_valid;
  logic                                       in_ready;
  logic [layer_index_size-1:0]                read_layer_index;
  logic [row_index_size-1:0]                  read_row_index;
  logic [channel_count-1:0]                   channel_mask;
  logic [channel_count-1:0]                   out_valid;
  logic [channel_count-1:0]                   out_ready;
  logic [channel_count*layer_index_size-1:0]  read_layer_index_out;
  logic [channel_count*row_index_size-1:0]    read_row_index_out;
  logic [count_size-1:0]                      accepted_count;
  logic                                       busy;

  modport master (
    output in_valid, read_layer_index, read_row_index, channel_mask, out_ready,
    input  in_ready, out_valid, read_layer_index_out, read_row_index_out, accepted_count, busy
  );

  modport slave (
    input  in_valid, read_layer_index, read_row_index, channel_mask, out_ready,
    output in_ready, out_valid, read_layer_index_out, read_row_index_out, accepted_count, busy
  );
endinterface

// File: rtl/matrix_location_broadcaster.sv
// rtl/matrix_location_broadcaster.sv - registers one (layer, row) location and broadcasts it to masked consumers
module matrix_location_broadcaster #(
  parameter int layer_index_size = 32,
  parameter int row_index_size   = 32,
  parameter int channel_count    = 2,
  parameter int count_size       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  matrix_location_broadcaster_if.slave  bus
);

  logic [layer_index_size-1:0] layer_reg;
  logic [row_index_size-1:0]   row_reg;
  logic [channel_count-1:0]    pending;
  logic [count_size-1:0]       count_reg;
  logic [channel_count-1:0]    remaining;
  logic                        accept;

  // Upstream may be accepted in the same cycle the last pending channels complete.
  assign remaining    = pending & ~bus.out_ready;
  assign bus.in_ready = ~|remaining;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      layer_reg <= '0;
      row_reg   <= '0;
      pending   <= '0;
      count_reg <= '0;
    end else if (accept) begin
      layer_reg <= bus.read_layer_index;
      row_reg   <= bus.read_row_index;
      pending   <= bus.channel_mask;
      count_reg <= count_reg + count_size'(1);
    end else begin
      pending   <= remaining;
    end
  end

  assign bus.out_valid            = pending;
  assign bus.read_layer_index_out = {channel_count{layer_reg}};
  assign bus.read_row_index_out   = {channel_count{row_reg}};
  assign bus.accepted_count       = count_reg;
  assign bus.busy                 = |pending;

endmodule

// File: doc/matrix_location_broadcaster.md
Name: matrix_location_broadcaster

Overview:
- Registered, handshaked successor to the two-way combinational location splitter.
- Captures one (layer index, row index) read location from an upstream producer.
- Broadcasts the location to `channel_count` independent consumers, e.g. parallel weight/activation memory readers.
- Each consumer accepts independently; upstream is released only when every enabled consumer has taken the location.
- A per-transaction channel mask selects which consumers receive each location.

Parameters:
- layer_index_size, 32, width of the layer index.
- row_index_size, 32, width of the row index.
- channel_count, 2, number of consumer channels (≥1).
- count_size, 16, width of the accepted-transaction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream location valid.
- in_ready  output  1  block can accept a location this cycle.
- read_layer_index  input  layer_index_size  upstream layer index.
- read_row_index  input  row_index_size  upstream row index.
- channel_mask  input  channel_count  consumers that receive this location; sampled with in_valid.
- out_valid  output  channel_count  per-channel location valid.
- out_ready  input  channel_count  per-channel consumer ready.
- read_layer_index_out  output  channel_count*layer_index_size  replicated layer index; channel k at slice [k*layer_index_size +: layer_index_size].
- read_row_index_out  output  channel_count*row_index_size  replicated row index, same slicing.
- accepted_count  output  count_size  number of accepted upstream transactions.
- busy  output  1  at least one channel still pending.

Behaviour:
- State:
  - layer_reg and row_reg: one shared data register pair.
  - pending[channel_count]: one flag per channel.
  - count_reg.
- Outputs:
  - out_valid = pending.
  - Every channel's output slices are driven from layer_reg/row_reg; all channels always show identical data.
  - busy = |pending.
- Handshakes:
  - Channel k completes on a cycle where pending[k] && out_ready[k].
  - remaining = pending & ~out_ready.
  - in_ready = (remaining == 0), combinational from pending and out_ready. This allows back-to-back transfers at one location per cycle when all consumers are ready.
  - Upstream accept = in_valid && in_ready.
- On accept (next edge):
  - layer_reg <= read_layer_index; row_reg <= read_row_index.
  - pending <= channel_mask.
  - count_reg <= count_reg + 1, wrapping modulo 2^count_size.
- No accept, next edge: pending <= remaining; data registers hold.
- Latency: location visible on out_valid and data outputs one cycle after accept.
- Data stability: data registers never change while any pending bit is set, except on an accept in the same cycle as the last completions.
- Zero mask: an accepted transaction with channel_mask == 0 is counted, but pending stays 0. It produces no out_valid and in_ready remains 1.
- Ready without valid: out_ready on a non-pending channel is ignored.
- in_valid low: in_ready may still be 1; nothing is captured and the count is unchanged.
- Upstream stalling: producer must hold read_layer_index, read_row_index and channel_mask stable while in_valid && !in_ready. The block does not depend on this but the bench checks it.
- Reset (asynchronous assert, any time including mid-broadcast):
  - pending = 0, layer_reg = 0, row_reg = 0, count_reg = 0.
  - Hence out_valid = 0, all data outputs 0, busy = 0, accepted_count = 0.
  - in_ready = 1 while reset is held (combinational from pending = 0); upstream must not treat this as an accept.
  - An in-flight location is discarded.
  - First accept is possible on the first rising edge after reset deasserts.
- channel_count = 1 degenerates to a single registered valid/ready stage.

Test Plan:
- Reset then single broadcast:
  - Stimulus: channel_count=2; in_valid=1 with layer=3, row=7, mask=2'b11; out_ready=2'b11.
  - Response: next cycle out_valid=2'b11 and both slices show 3/7; following cycle out_valid=0; accepted_count=1.
- Staggered consumers:
  - Stimulus: mask=2'b11; out_ready[0]=1 at cycle 1; out_ready[1] held 0 until cycle 4.
  - Response: pending goes 2'b11 → 2'b10 → 2'b10 → 2'b10 → 0; in_ready=0 during cycles 1–3 and 1 at cycle 4; data stays 3/7 throughout.
- Back-to-back throughput:
  - Stimulus: 4 consecutive locations (layer=i, row=10+i, i=0..3); out_ready always 1.
  - Response: one location per cycle; out_valid continuously 2'b11 for 4 cycles; accepted_count=4.
- Masking:
  - Stimulus: channel_count=4, mask=4'b0101; then a transaction with mask=0.
  - Response: only out_valid[0] and out_valid[2] assert for the first; the zero-mask transaction raises no out_valid; accepted_count increments for both.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between edges) while pending=2'b10.
  - Response: out_valid, busy, data outputs and accepted_count go to 0 immediately, without waiting for a clock edge; after deassert a new location (layer=9, row=1) broadcasts normally.
- Counter wrap:
  - Stimulus: count_size=4; 17 accepts.
  - Response: accepted_count reads 1.
